// File: rtl/datamover_cmd_sched_if.sv
// Command/status stream pair between the scheduler and one DataMover channel.
// The master side drives commands and accepts statuses; the slave side is the DataMover.
interface datamover_cmd_sched_if;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [71:0] cmd_tdata;
  logic        sts_tvalid;
  logic        sts_tready;
  logic [7:0]  sts_tdata;

  modport master (
    output cmd_tvalid, cmd_tdata, sts_tready,
    input  cmd_tready, sts_tvalid, sts_tdata
  );

  modport slave (
    input  cmd_tvalid, cmd_tdata, sts_tready,
    output cmd_tready, sts_tvalid, sts_tdata
  );
endinterface

// File: rtl/datamover_cmd_sched.sv
// Splits a host job into DataMover INCR commands of at most C_MAX_BTT bytes, keeps up to
// C_MAX_OUTST of them in flight, retires statuses and reports done/error/irq.
module datamover_cmd_sched #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 32,
  parameter int C_MAX_BTT    = 4096,
  parameter int C_MAX_OUTST  = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  datamover_cmd_sched_if.master    dm,
  input  logic                     job_start,
  input  logic [C_ADDR_WIDTH-1:0]  job_addr,
  input  logic [C_LEN_WIDTH-1:0]   job_len,
  input  logic                     job_abort,
  input  logic                     irq_clr,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               err_flags,
  output logic                     start_dropped,
  output logic                     irq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [C_LEN_WIDTH-1:0] MAX_BTT_L   = C_LEN_WIDTH'(C_MAX_BTT);
  localparam logic [3:0]             MAX_OUTST_L = 4'(C_MAX_OUTST);

  state_t                    state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic [3:0]                tag_issue_q, tag_issue_d;
  logic [3:0]                tag_exp_q, tag_exp_d;
  logic [3:0]                outst_q, outst_d;
  logic                      abort_q, abort_d;
  logic                      cmd_tvalid_q, cmd_tvalid_d;
  logic [71:0]               cmd_tdata_q, cmd_tdata_d;
  logic                      done_q, done_d;
  logic                      irq_q, irq_d;
  logic [3:0]                err_q, err_d;
  logic                      drop_q, drop_d;

  logic                      cmd_acc, cmd_hold, sts_acc;
  logic                      sts_dm_err, sts_tag_bad, issue_ok, eof;
  logic [C_LEN_WIDTH-1:0]    btt;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    tag_issue_d  = tag_issue_q;
    tag_exp_d    = tag_exp_q;
    abort_d      = abort_q;
    cmd_tvalid_d = cmd_tvalid_q;
    cmd_tdata_d  = cmd_tdata_q;
    done_d       = 1'b0;
    err_d        = err_q & ~{4{irq_clr}};
    drop_d       = drop_q & ~irq_clr;

    cmd_acc     = cmd_tvalid_q & dm.cmd_tready;
    cmd_hold    = cmd_tvalid_q & ~dm.cmd_tready;
    sts_acc     = dm.sts_tvalid & (outst_q != 4'd0);
    sts_dm_err  = ~dm.sts_tdata[7] | (|dm.sts_tdata[6:4]);
    sts_tag_bad = dm.sts_tdata[3:0] != tag_exp_q;

    // The accepted command's BTT is the amount of the job it consumed.
    if (cmd_acc) begin
      addr_d      = addr_q + C_ADDR_WIDTH'(cmd_tdata_q[22:0]);
      remaining_d = remaining_q - C_LEN_WIDTH'(cmd_tdata_q[22:0]);
      tag_issue_d = tag_issue_q + 4'd1;
    end
    outst_d = outst_q + 4'(cmd_acc) - 4'(sts_acc);

    if (sts_acc) begin
      tag_exp_d = tag_exp_q + 4'd1;
      if (sts_dm_err) begin
        err_d[1] = 1'b1;
        abort_d  = 1'b1;
      end
      if (sts_tag_bad) begin
        err_d[3] = 1'b1;
        abort_d  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          if (job_len == '0) begin
            err_d[0] = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            addr_d      = job_addr;
            remaining_d = job_len;
            abort_d     = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (job_abort) begin
          abort_d  = 1'b1;
          err_d[2] = 1'b1;
        end
        // A presented command must finish its handshake before we stop issuing.
        if (!cmd_hold && ((remaining_d == '0) || abort_d))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (job_abort)
          err_d[2] = 1'b1;
        if (outst_q == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          abort_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (job_start && (state_q != S_IDLE))
      drop_d = 1'b1;

    irq_d = (irq_q & ~irq_clr) | done_d;

    btt      = (remaining_d > MAX_BTT_L) ? MAX_BTT_L : remaining_d;
    eof      = (btt == remaining_d);
    issue_ok = (state_d == S_ISSUE) && (remaining_d != '0) &&
               (outst_d < MAX_OUTST_L) && !abort_d;

    if (!cmd_hold) begin
      cmd_tvalid_d = issue_ok;
      cmd_tdata_d  = issue_ok ? {4'b0, tag_issue_d, 32'(addr_d), 1'b0, eof, 6'b0, 1'b1, 23'(btt)}
                              : 72'd0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      tag_issue_q  <= '0;
      tag_exp_q    <= '0;
      outst_q      <= '0;
      abort_q      <= 1'b0;
      cmd_tvalid_q <= 1'b0;
      cmd_tdata_q  <= '0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      tag_issue_q  <= tag_issue_d;
      tag_exp_q    <= tag_exp_d;
      outst_q      <= outst_d;
      abort_q      <= abort_d;
      cmd_tvalid_q <= cmd_tvalid_d;
      cmd_tdata_q  <= cmd_tdata_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  assign dm.cmd_tvalid = cmd_tvalid_q;
  assign dm.cmd_tdata  = cmd_tdata_q;
  assign dm.sts_tready = (outst_q != 4'd0);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err_flags     = err_q;
  assign start_dropped = drop_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_datamover_cmd_sched.sv
// Bench for datamover_cmd_sched: a randomized DataMover responder plus a job-level model that
// derives the expected command list from address, length and the running tag count.
module tb_datamover_cmd_sched;
  localparam int MAX_BTT   = 4096;
  localparam int MAX_OUTST = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        job_start = 1'b0;
  logic [31:0] job_addr = '0;
  logic [31:0] job_len = '0;
  logic        job_abort = 1'b0;
  logic        irq_clr = 1'b0;
  logic        busy, done, start_dropped, irq;
  logic [3:0]  err_flags;

  datamover_cmd_sched_if dm_bus();

  datamover_cmd_sched #(
    .C_ADDR_WIDTH (32),
    .C_LEN_WIDTH  (32),
    .C_MAX_BTT    (MAX_BTT),
    .C_MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .dm            (dm_bus),
    .job_start     (job_start),
    .job_addr      (job_addr),
    .job_len       (job_len),
    .job_abort     (job_abort),
    .irq_clr       (irq_clr),
    .busy          (busy),
    .done          (done),
    .err_flags     (err_flags),
    .start_dropped (start_dropped),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [71:0] exp_cmds[$];
  logic [71:0] cmd_log[$];
  logic [3:0]  tag_q[$];
  logic [3:0]  tag_model = '0;
  int          done_cnt = 0;
  int          rdy_pct = 100;
  bit          sts_hold = 1'b0;
  int          sts_n = 0;
  int          bad_idx = -1;
  logic [3:0]  bad_hi = 4'h8;
  bit          sts_taken, prev_v, prev_r;
  logic [71:0] prev_d;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_sts();
    logic [3:0] t;
    t = tag_q.pop_front();
    dm_bus.sts_tdata  = {(sts_n == bad_idx) ? bad_hi : 4'h8, t};
    dm_bus.sts_tvalid = 1'b1;
    sts_n++;
  endtask

  // Advance one clock: log handshakes completing at the edge, then drive the next inputs.
  task automatic cycle();
    prev_v = dm_bus.cmd_tvalid;
    prev_r = dm_bus.cmd_tready;
    prev_d = dm_bus.cmd_tdata;
    if (dm_bus.cmd_tvalid && dm_bus.cmd_tready) begin
      cmd_log.push_back(dm_bus.cmd_tdata);
      tag_q.push_back(dm_bus.cmd_tdata[67:64]);
    end
    sts_taken = dm_bus.sts_tvalid && dm_bus.sts_tready;
    @(posedge clk);
    @(negedge clk);
    job_start = 1'b0;
    job_abort = 1'b0;
    irq_clr   = 1'b0;
    if (done) done_cnt++;
    if (prev_v && !prev_r) begin
      check_val("cmd_hold_valid", 72'(dm_bus.cmd_tvalid), 72'(1));
      check_val("cmd_hold_data", dm_bus.cmd_tdata, prev_d);
    end
    if (sts_taken) dm_bus.sts_tvalid = 1'b0;
    dm_bus.cmd_tready = (int'($urandom_range(99)) < rdy_pct);
    if (!dm_bus.sts_tvalid && !sts_hold && tag_q.size() > 0 && $urandom_range(3) != 0)
      send_sts();
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] l);
    logic [31:0] ad, rem, b;
    logic [3:0]  t;
    ad = a;
    rem = l;
    t = tag_model;
    exp_cmds.delete();
    cmd_log.delete();
    done_cnt = 0;
    while (rem != 0) begin
      b = (rem > 32'(MAX_BTT)) ? 32'(MAX_BTT) : rem;
      exp_cmds.push_back({4'h0, t, ad, 1'b0, (rem == b), 6'h0, 1'b1, b[22:0]});
      ad  = ad + b;
      rem = rem - b;
      t   = t + 4'd1;
    end
    job_addr  = a;
    job_len   = l;
    job_start = 1'b1;
    cycle();
  endtask

  task automatic finish_job(input string name, input int n_exp, input logic [3:0] flags_exp);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      cycle();
      n++;
    end
    check_val({name, "_done_seen"}, 72'(done_cnt > 0), 72'(1));
    cycle();
    cycle();
    check_val({name, "_done_pulses"}, 72'(done_cnt), 72'(1));
    check_val({name, "_cmd_count"}, 72'(cmd_log.size()), 72'(n_exp));
    for (int i = 0; i < n_exp && i < cmd_log.size(); i++)
      check_val($sformatf("%s_cmd%0d", name, i), cmd_log[i], exp_cmds[i]);
    check_val({name, "_flags"}, 72'(err_flags), 72'(flags_exp));
    check_val({name, "_irq"}, 72'(irq), 72'(1));
    check_val({name, "_busy"}, 72'(busy), 72'(0));
    $display("job %s addr=0x%08h len=%0d cmds=%0d flags=%b", name, job_addr, job_len,
             cmd_log.size(), err_flags);
    tag_model = tag_model + 4'(n_exp);
    irq_clr = 1'b1;
    cycle();
    check_val({name, "_irq_clr"}, 72'(irq), 72'(0));
    check_val({name, "_flags_clr"}, 72'(err_flags), 72'(0));
    check_val({name, "_drop_clr"}, 72'(start_dropped), 72'(0));
  endtask

  initial begin
    logic [31:0] ra, rl;
    dm_bus.cmd_tready = 1'b0;
    dm_bus.sts_tvalid = 1'b0;
    dm_bus.sts_tdata  = '0;
    repeat (2) @(negedge clk);
    check_val("rst_tvalid", 72'(dm_bus.cmd_tvalid), 72'(0));
    check_val("rst_tdata", dm_bus.cmd_tdata, 72'(0));
    check_val("rst_sts_tready", 72'(dm_bus.sts_tready), 72'(0));
    check_val("rst_busy", 72'(busy), 72'(0));
    check_val("rst_done", 72'(done), 72'(0));
    check_val("rst_flags", 72'(err_flags), 72'(0));
    check_val("rst_irq", 72'(irq), 72'(0));
    aresetn = 1'b1;
    cycle();

    // T1: three chunks with random backpressure
    rdy_pct = 60;
    start_job(32'h1000_0000, 32'd10000);
    finish_job("t1", 3, 4'b0000);

    // T2: outstanding limit with statuses withheld
    rdy_pct = 100;
    sts_hold = 1'b1;
    start_job(32'h2000_0000, 32'd40960);
    repeat (12) cycle();
    check_val("t2_issued_at_limit", 72'(cmd_log.size()), 72'(MAX_OUTST));
    check_val("t2_tvalid_stalled", 72'(dm_bus.cmd_tvalid), 72'(0));
    send_sts();
    cycle();
    check_val("t2_refill_valid", 72'(dm_bus.cmd_tvalid), 72'(1));
    check_val("t2_refill_data", dm_bus.cmd_tdata, exp_cmds[4]);
    sts_hold = 1'b0;
    finish_job("t2", 10, 4'b0000);

    // T3: second status of the job reports SLVERR
    sts_hold = 1'b1;
    start_job(32'h3000_0000, 32'd24576);
    repeat (8) cycle();
    send_sts();
    cycle();
    repeat (3) cycle();
    bad_idx = sts_n;
    bad_hi  = 4'h4;
    send_sts();
    cycle();
    repeat (4) cycle();
    check_val("t3_no_more_cmds", 72'(dm_bus.cmd_tvalid), 72'(0));
    sts_hold = 1'b0;
    bad_idx  = -1;
    finish_job("t3", 5, 4'b0010);

    // T4: zero-length job
    start_job(32'h4000_0000, 32'd0);
    check_val("t4_done", 72'(done), 72'(1));
    check_val("t4_tvalid", 72'(dm_bus.cmd_tvalid), 72'(0));
    check_val("t4_flags", 72'(err_flags), 72'(1));
    check_val("t4_irq", 72'(irq), 72'(1));
    cycle();
    check_val("t4_done_pulse", 72'(done), 72'(0));
    irq_clr = 1'b1;
    cycle();
    check_val("t4_irq_clr", 72'(irq), 72'(0));
    check_val("t4_flags_clr", 72'(err_flags), 72'(0));

    // T5: abort while a command is stalled, then a start while busy
    rdy_pct = 0;
    start_job(32'h5000_0000, 32'd12288);
    check_val("t5_tvalid", 72'(dm_bus.cmd_tvalid), 72'(1));
    job_abort = 1'b1;
    cycle();
    check_val("t5_abort_keeps_valid", 72'(dm_bus.cmd_tvalid), 72'(1));
    rdy_pct = 100;
    dm_bus.cmd_tready = 1'b1;
    finish_job("t5", 1, 4'b0100);

    rdy_pct = 50;
    start_job(32'h6000_0000, 32'd8192);
    cycle();
    job_addr  = 32'hDEAD_0000;
    job_len   = 32'd100;
    job_start = 1'b1;
    cycle();
    check_val("t5_start_dropped", 72'(start_dropped), 72'(1));
    finish_job("t5b", 2, 4'b0000);

    // T6: single-chunk jobs walk the tag through its wrap, then random multi-chunk jobs
    for (int j = 0; j < 20; j++) begin
      rdy_pct = int'($urandom_range(100, 30));
      ra = $urandom;
      rl = $urandom_range(MAX_BTT, 1);
      start_job(ra, rl);
      finish_job($sformatf("t6_%0d", j), 1, 4'b0000);
    end
    for (int j = 0; j < 5; j++) begin
      rdy_pct = int'($urandom_range(100, 20));
      ra = $urandom;
      rl = $urandom_range(30000, 1);
      start_job(ra, rl);
      finish_job($sformatf("t6r_%0d", j), exp_cmds.size(), 4'b0000);
    end

    // Reset in the middle of a job
    rdy_pct = 100;
    start_job(32'h7000_0000, 32'd40960);
    repeat (3) cycle();
    #2 aresetn = 1'b0;
    #1;
    check_val("mrst_tvalid", 72'(dm_bus.cmd_tvalid), 72'(0));
    check_val("mrst_tdata", dm_bus.cmd_tdata, 72'(0));
    check_val("mrst_sts_tready", 72'(dm_bus.sts_tready), 72'(0));
    check_val("mrst_busy", 72'(busy), 72'(0));
    check_val("mrst_irq", 72'(irq), 72'(0));
    check_val("mrst_flags", 72'(err_flags), 72'(0));
    dm_bus.sts_tvalid = 1'b0;
    tag_q.delete();
    cmd_log.delete();
    tag_model = '0;
    @(negedge clk);
    aresetn = 1'b1;
    cycle();
    start_job(32'h1000_0000, 32'd10000);
    finish_job("post_rst", 3, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
